// File: rtl/pmul_row_seq.sv
// Row sequencer for the 3-lane pmul: issues the three window/kernel rows, accumulates the psums.
// Optional WAIT timeout is built only when PMUL_TIMEOUT_EN is defined.
module pmul_row_seq #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = WIDTH + 2,
    parameter int MIN_WAIT  = 1,
    parameter int TIMEOUT   = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [9*WIDTH-1:0]     in_win,
    input  logic [9*WIDTH-1:0]     in_kern,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   pm_update,
    output logic [WIDTH-1:0]       pm_data2,
    output logic [WIDTH-1:0]       pm_data1,
    output logic [WIDTH-1:0]       pm_data0,
    output logic [WIDTH-1:0]       pm_weight2,
    output logic [WIDTH-1:0]       pm_weight1,
    output logic [WIDTH-1:0]       pm_weight0,
    input  logic [WIDTH-1:0]       pm_psum,
    input  logic                   pm_psum_vld,
    output logic [ACC_WIDTH-1:0]   out_sum,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_err
);

    localparam int CNT_W = $clog2(TIMEOUT + MIN_WAIT + 2);
    localparam logic [CNT_W-1:0] MIN_WAIT_C = CNT_W'(MIN_WAIT);
`ifdef PMUL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [9*WIDTH-1:0]     win_reg, kern_reg;
    logic [1:0]             row_reg, row_next;
    logic [ACC_WIDTH-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [3*WIDTH-1:0]     pm_data_reg, pm_weight_reg;
`ifdef PMUL_TIMEOUT_EN
    logic                   err_reg, err_next;
`endif

    logic                   load_en, load_from_in, accept;
    logic [1:0]             load_row;
    logic [9*WIDTH-1:0]     src_win, src_kern;
    logic [3*WIDTH-1:0]     row_data, row_weight;

    // Row operands are loaded on the edge that enters ISSUE, so they are already valid with the pulse.
    assign src_win  = load_from_in ? in_win  : win_reg;
    assign src_kern = load_from_in ? in_kern : kern_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_col
            assign row_data[gi*WIDTH +: WIDTH]   = src_win[WIDTH*(3*int'(load_row) + gi) +: WIDTH];
            assign row_weight[gi*WIDTH +: WIDTH] = src_kern[WIDTH*(3*int'(load_row) + gi) +: WIDTH];
        end
    endgenerate

    assign accept = (state_reg == WAIT) && pm_psum_vld && (cnt_reg >= MIN_WAIT_C);

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next   = state_reg;
        row_next     = row_reg;
        acc_next     = acc_reg;
        cnt_next     = cnt_reg;
        load_en      = 1'b0;
        load_from_in = 1'b0;
        load_row     = row_reg;
`ifdef PMUL_TIMEOUT_EN
        err_next     = err_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next   = ISSUE;
                    row_next     = 2'd0;
                    acc_next     = '0;
                    load_en      = 1'b1;
                    load_from_in = 1'b1;
                    load_row     = 2'd0;
`ifdef PMUL_TIMEOUT_EN
                    err_next     = 1'b0;
`endif
                end
            end
            ISSUE: begin
                cnt_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                // Saturate so a long stall can never wrap back into the blanking window.
                cnt_next = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
                if (accept) begin
                    acc_next = acc_reg + ACC_WIDTH'(pm_psum);
                    if (row_reg == 2'd2) begin
                        state_next = DONE;
                    end else begin
                        row_next   = row_reg + 2'd1;
                        load_en    = 1'b1;
                        load_row   = row_reg + 2'd1;
                        state_next = ISSUE;
                    end
                end
`ifdef PMUL_TIMEOUT_EN
                else if (cnt_reg >= TIMEOUT_C) begin
                    acc_next   = '0;
                    err_next   = 1'b1;
                    state_next = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
`ifdef PMUL_TIMEOUT_EN
                    err_next   = 1'b0;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_reg       <= '0;
            kern_reg      <= '0;
            row_reg       <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            pm_data_reg   <= '0;
            pm_weight_reg <= '0;
`ifdef PMUL_TIMEOUT_EN
            err_reg       <= 1'b0;
`endif
        end else begin
            row_reg <= row_next;
            acc_reg <= acc_next;
            cnt_reg <= cnt_next;
`ifdef PMUL_TIMEOUT_EN
            err_reg <= err_next;
`endif
            if (load_from_in) begin
                win_reg  <= in_win;
                kern_reg <= in_kern;
            end
            if (load_en) begin
                pm_data_reg   <= row_data;
                pm_weight_reg <= row_weight;
            end
        end
    end

    assign in_ready   = (state_reg == IDLE);
    assign pm_update  = (state_reg == ISSUE);
    assign out_valid  = (state_reg == DONE);
    assign out_sum    = acc_reg;
    assign pm_data0   = pm_data_reg[0*WIDTH +: WIDTH];
    assign pm_data1   = pm_data_reg[1*WIDTH +: WIDTH];
    assign pm_data2   = pm_data_reg[2*WIDTH +: WIDTH];
    assign pm_weight0 = pm_weight_reg[0*WIDTH +: WIDTH];
    assign pm_weight1 = pm_weight_reg[1*WIDTH +: WIDTH];
    assign pm_weight2 = pm_weight_reg[2*WIDTH +: WIDTH];
`ifdef PMUL_TIMEOUT_EN
    assign out_err    = err_reg;
`else
    assign out_err    = 1'b0;
`endif

endmodule
